// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose: turns field-level RV32I commands (R, I-ALU, LOAD, STORE, BRANCH)
// into 32-bit machine words and writes them to consecutive instruction
// memory addresses. Used to fill instruction memory at bring-up.
//
// Handshake: a command transfers on a rising edge where i_cmd_valid and
// o_cmd_ready are both high. The producer holds the command stable while
// i_cmd_valid is high and o_cmd_ready is low. o_cmd_ready is high only in
// RUN, so at most one command is accepted every two cycles. A command that
// transfers in cycle N produces o_mem_we in cycle N+1.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-low reset
//   i_start             pulse: clear address/count/errors and begin a load
//   i_cmd_valid/o_cmd_ready  command handshake
//   i_cmd_last          command is the last of the load
//   i_cmd_class         0=R 1=I-ALU 2=LOAD 3=STORE 4=BRANCH, 5..7 illegal
//   i_cmd_rd/rs1/rs2    register fields
//   i_cmd_funct3        funct3 field
//   i_cmd_alt           funct7[5] for R-type and I-ALU shifts
//   i_cmd_imm           13-bit signed immediate (byte offset for branches)
//   o_mem_we/addr/wdata instruction memory write port
//   o_busy              high in RUN or WRITE
//   o_done              one-cycle pulse when a load completes
//   o_err, o_err_code   sticky error: 1=illegal class, 2=imm range, 3=full
//   o_word_count        words written since start
//   o_state             current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_last,
    input  logic [2:0]  i_cmd_class,
    input  logic [4:0]  i_cmd_rd,
    input  logic [4:0]  i_cmd_rs1,
    input  logic [4:0]  i_cmd_rs2,
    input  logic [2:0]  i_cmd_funct3,
    input  logic        i_cmd_alt,
    input  logic [12:0] i_cmd_imm,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [6:0]  o_word_count,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [6:0] LP_DEPTH     = 7'(DEPTH_WORDS);
    localparam logic [1:0] LP_ERR_CLASS = 2'd1;
    localparam logic [1:0] LP_ERR_IMM   = 2'd2;
    localparam logic [1:0] LP_ERR_FULL  = 2'd3;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_mem_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [6:0]  r_word_count;
    logic        r_last;

    logic        w_is_shift;
    logic        w_imm_fits12;
    logic        w_imm_bad;
    logic [1:0]  w_chk_code;
    logic [31:0] w_word;
    logic        w_start_ok;

    // Encoder and handshake checks, evaluated on the presented command.
    always_comb begin
        // funct3 001 (SLLI) and 101 (SRLI/SRAI) are the shift forms
        w_is_shift   = (i_cmd_class == 3'd1) && (i_cmd_funct3[1:0] == 2'b01);
        // a 12-bit immediate fits when bit 12 is a pure sign extension
        w_imm_fits12 = (i_cmd_imm[12] == i_cmd_imm[11]);
        w_word       = 32'd0;
        w_imm_bad    = 1'b0;
        w_chk_code   = 2'd0;

        case (i_cmd_class)
            3'd0: w_word = {1'b0, i_cmd_alt, 5'b00000, i_cmd_rs2, i_cmd_rs1,
                            i_cmd_funct3, i_cmd_rd, 7'b0110011};
            3'd1: begin
                if (w_is_shift)
                    w_word = {1'b0, i_cmd_alt, 5'b00000, i_cmd_imm[4:0], i_cmd_rs1,
                              i_cmd_funct3, i_cmd_rd, 7'b0010011};
                else
                    w_word = {i_cmd_imm[11:0], i_cmd_rs1, i_cmd_funct3,
                              i_cmd_rd, 7'b0010011};
                w_imm_bad = !w_imm_fits12 || (w_is_shift && (|i_cmd_imm[11:5]));
            end
            3'd2: begin
                w_word    = {i_cmd_imm[11:0], i_cmd_rs1, i_cmd_funct3,
                             i_cmd_rd, 7'b0000011};
                w_imm_bad = !w_imm_fits12;
            end
            3'd3: begin
                w_word    = {i_cmd_imm[11:5], i_cmd_rs2, i_cmd_rs1, i_cmd_funct3,
                             i_cmd_imm[4:0], 7'b0100011};
                w_imm_bad = !w_imm_fits12;
            end
            3'd4: begin
                w_word    = {i_cmd_imm[12], i_cmd_imm[10:5], i_cmd_rs2, i_cmd_rs1,
                             i_cmd_funct3, i_cmd_imm[4:1], i_cmd_imm[11], 7'b1100011};
                w_imm_bad = i_cmd_imm[0];
            end
            default: w_word = 32'd0;
        endcase

        // priority: class, then full, then immediate range
        if (i_cmd_class > 3'd4)
            w_chk_code = LP_ERR_CLASS;
        else if (r_word_count == LP_DEPTH)
            w_chk_code = LP_ERR_FULL;
        else if (w_imm_bad)
            w_chk_code = LP_ERR_IMM;
    end

    // start is only honoured outside an active load
    assign w_start_ok = i_start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
            r_word_count <= 7'd0;
            r_last       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            if (w_start_ok) begin
                r_state      <= S_RUN;
                r_cmd_ready  <= 1'b1;
                r_busy       <= 1'b1;
                r_addr       <= BASE_ADDR;
                r_word_count <= 7'd0;
                r_err        <= 1'b0;
                r_err_code   <= 2'd0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (i_cmd_valid && r_cmd_ready) begin
                            r_cmd_ready <= 1'b0;
                            if (w_chk_code != 2'd0) begin
                                r_state    <= S_ERR;
                                r_busy     <= 1'b0;
                                r_err      <= 1'b1;
                                r_err_code <= w_chk_code;
                            end else begin
                                r_state  <= S_WRITE;
                                r_wdata  <= w_word;
                                r_last   <= i_cmd_last;
                                r_mem_we <= 1'b1;
                            end
                        end
                    end
                    S_WRITE: begin
                        r_addr       <= r_addr + 32'd4;
                        r_word_count <= r_word_count + 7'd1;
                        if (r_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= r_state;   // IDLE and ERR wait for start
                endcase
            end
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;
    assign o_word_count = r_word_count;
    assign o_state      = r_state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
`timescale 1ns/1ps
module tb_instr_encoder_loader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // shared command fields, per-instance start/valid
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        cmd_last = 1'b0;
    logic [2:0]  cmd_class = 3'd0;
    logic [4:0]  cmd_rd = 5'd0, cmd_rs1 = 5'd0, cmd_rs2 = 5'd0;
    logic [2:0]  cmd_funct3 = 3'd0;
    logic        cmd_alt = 1'b0;
    logic [12:0] cmd_imm = 13'd0;

    logic        ready0, we0, busy0, done0, err0;
    logic [31:0] addr0, wdata0;
    logic [1:0]  code0;
    logic [6:0]  count0;
    logic [2:0]  state0;

    logic        ready1, we1, busy1, done1, err1;
    logic [31:0] addr1, wdata1;
    logic [1:0]  code1;
    logic [6:0]  count1;
    logic [2:0]  state1;

    instr_encoder_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_cmd_valid(valid0),
        .o_cmd_ready(ready0), .i_cmd_last(cmd_last), .i_cmd_class(cmd_class),
        .i_cmd_rd(cmd_rd), .i_cmd_rs1(cmd_rs1), .i_cmd_rs2(cmd_rs2),
        .i_cmd_funct3(cmd_funct3), .i_cmd_alt(cmd_alt), .i_cmd_imm(cmd_imm),
        .o_mem_we(we0), .o_mem_addr(addr0), .o_mem_wdata(wdata0),
        .o_busy(busy0), .o_done(done0), .o_err(err0), .o_err_code(code0),
        .o_word_count(count0), .o_state(state0)
    );

    instr_encoder_loader #(.DEPTH_WORDS(2), .BASE_ADDR(32'h0000_0100)) dut_small (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_cmd_valid(valid1),
        .o_cmd_ready(ready1), .i_cmd_last(cmd_last), .i_cmd_class(cmd_class),
        .i_cmd_rd(cmd_rd), .i_cmd_rs1(cmd_rs1), .i_cmd_rs2(cmd_rs2),
        .i_cmd_funct3(cmd_funct3), .i_cmd_alt(cmd_alt), .i_cmd_imm(cmd_imm),
        .o_mem_we(we1), .o_mem_addr(addr1), .o_mem_wdata(wdata1),
        .o_busy(busy1), .o_done(done1), .o_err(err1), .o_err_code(code1),
        .o_word_count(count1), .o_state(state1)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];    // {addr, wdata} expected from dut
    logic [63:0] exp_q1[$];   // {addr, wdata} expected from dut_small

    // reference model state per instance
    int          m_count [2];
    logic [31:0] m_addr  [2];
    int          m_code  [2];
    int          m_depth [2] = '{64, 2};
    logic [31:0] m_base  [2] = '{32'h0, 32'h100};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int imm_value(input logic [12:0] imm);
        int u;
        u = int'(imm);
        return (u >= 4096) ? u - 8192 : u;
    endfunction

    function automatic bit is_shift(input logic [2:0] cls, input logic [2:0] f3);
        return (cls == 3'd1) && (f3 == 3'd1 || f3 == 3'd5);
    endfunction

    function automatic int ref_code(input int sel, input logic [2:0] cls,
                                    input logic [2:0] f3, input logic [12:0] imm);
        int v;
        v = imm_value(imm);
        if (cls > 3'd4) return 1;
        if (m_count[sel] == m_depth[sel]) return 3;
        if (cls == 3'd1 && is_shift(cls, f3)) return (v >= 0 && v <= 31) ? 0 : 2;
        if (cls == 3'd1 || cls == 3'd2 || cls == 3'd3) return (v >= -2048 && v <= 2047) ? 0 : 2;
        if (cls == 3'd4) return (v % 2 == 0) ? 0 : 2;
        return 0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [2:0] cls, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic alt,
                                            input logic [12:0] imm);
        logic [31:0] v, d, a, b, c, f, f7;
        v  = 32'(imm_value(imm));
        d  = 32'(rd);
        a  = 32'(rs1);
        b  = 32'(rs2);
        f  = 32'(f3);
        f7 = alt ? 32'd32 : 32'd0;
        c  = (a << 15) | (f << 12);
        case (cls)
            3'd0: return (f7 << 25) | (b << 20) | c | (d << 7) | 32'd51;
            3'd1: if (is_shift(cls, f3))
                      return (f7 << 25) | ((v & 32'd31) << 20) | c | (d << 7) | 32'd19;
                  else
                      return ((v & 32'hFFF) << 20) | c | (d << 7) | 32'd19;
            3'd2: return ((v & 32'hFFF) << 20) | c | (d << 7) | 32'd3;
            3'd3: return (((v >> 5) & 32'd127) << 25) | (b << 20) | c |
                         ((v & 32'd31) << 7) | 32'd35;
            3'd4: return (((v >> 12) & 32'd1) << 31) | (((v >> 5) & 32'd63) << 25) |
                         (b << 20) | c | (((v >> 1) & 32'd15) << 8) |
                         (((v >> 11) & 32'd1) << 7) | 32'd99;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic do_start(input int sel);
        pulse_start(sel);
        m_count[sel] = 0;
        m_addr[sel]  = m_base[sel];
        m_code[sel]  = 0;
    endtask

    task automatic send(input int sel, input logic [2:0] cls, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic alt, input logic [12:0] imm, input logic last,
                        input bit use_exp, input logic [31:0] exp_word);
        int cnt;
        int code;
        logic [31:0] w;
        @(negedge clk);
        cmd_class = cls; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_funct3 = f3; cmd_alt = alt; cmd_imm = imm; cmd_last = last;
        if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
        cnt = 0;
        while (!((sel == 0) ? ready0 : ready1) && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_ready_timeout: inst %0d got ready=0 expected ready=1", sel);
            valid0 = 1'b0;
            valid1 = 1'b0;
            return;
        end
        code = ref_code(sel, cls, f3, imm);
        w    = use_exp ? exp_word : ref_word(cls, rd, rs1, rs2, f3, alt, imm);
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        m_code[sel] = code;
        if (code == 0) begin
            if (sel == 0) exp_q.push_back({m_addr[sel], w});
            else          exp_q1.push_back({m_addr[sel], w});
            m_count[sel]++;
            m_addr[sel] = m_addr[sel] + 32'd4;
        end
    endtask

    task automatic wait_done(input int sel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if ((sel == 0) ? done0 : done1) seen = 1'b1;
        end
        check("done_pulse", 32'(seen), 32'd1);
        check("word_count_at_done", 32'((sel == 0) ? count0 : count1), 32'(m_count[sel]));
        check("addr_at_done", (sel == 0) ? addr0 : addr1, m_addr[sel]);
        check("busy_at_done", 32'((sel == 0) ? busy0 : busy1), 32'd0);
    endtask

    task automatic check_err(input int sel);
        repeat (2) @(negedge clk);
        check("err_flag", 32'((sel == 0) ? err0 : err1), 32'd1);
        check("err_code", 32'((sel == 0) ? code0 : code1), 32'(m_code[sel]));
        check("err_ready_low", 32'((sel == 0) ? ready0 : ready1), 32'd0);
        check("err_count_held", 32'((sel == 0) ? count0 : count1), 32'(m_count[sel]));
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (we0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: addr=%h data=%h expected no write", addr0, wdata0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({addr0, wdata0} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h",
                             addr0, wdata0, e[63:32], e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (we1) begin
            n_cmp++;
            if (exp_q1.size() == 0) begin
                n_fail++;
                $display("FAIL small_write_unexpected: addr=%h data=%h expected no write", addr1, wdata1);
            end else begin
                logic [63:0] e;
                e = exp_q1.pop_front();
                if ({addr1, wdata1} !== e) begin
                    n_fail++;
                    $display("FAIL small_write: got addr=%h data=%h expected addr=%h data=%h",
                             addr1, wdata1, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic [12:0] imm;
        int          len;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state0), 32'd0);
        check("rst_outputs", {ready0, we0, busy0, done0, err0, code0, count0}, 32'd0);
        check("rst_addr", addr0, 32'd0);
        check("rst_wdata", wdata0, 32'd0);
        rst = 1'b1;

        // valid held in IDLE never gets ready
        valid0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ready_low", 32'(ready0), 32'd0);
        end
        valid0 = 1'b0;

        // single R-type
        do_start(0);
        check("run_busy", 32'(busy0), 32'd1);
        send(0, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b1, 1'b1, 32'h002081B3);
        wait_done(0);

        // LOAD then STORE, with an ignored start in between
        do_start(0);
        send(0, 3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 13'd8, 1'b0, 1'b1, 32'h00812283);
        pulse_start(0);
        send(0, 3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 13'd12, 1'b1, 1'b1, 32'h00512623);
        wait_done(0);

        // BRANCH -8 and SUB
        do_start(0);
        send(0, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8, 1'b0, 1'b1, 32'hFE208CE3);
        send(0, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0, 1'b1, 1'b1, 32'h402081B3);
        wait_done(0);

        // error cases
        do_start(0);
        send(0, 3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd0, 1'b0, 1'b0, 32'd0);
        check_err(0);
        do_start(0);
        check("err_cleared_by_start", 32'(err0), 32'd0);
        send(0, 3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 13'h0800, 1'b0, 1'b0, 32'd0);
        check_err(0);
        do_start(0);
        send(0, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'd5, 1'b0, 1'b0, 32'd0);
        check_err(0);

        // randomized loads
        for (int l = 0; l < 12; l++) begin
            bit errored;
            errored = 1'b0;
            do_start(0);
            len = $urandom_range(1, 8);
            for (int i = 0; i < len && !errored; i++) begin
                cls = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                f3  = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0)
                    imm = 13'($urandom);
                else
                    imm = 13'(int'($urandom_range(0, 63)) - 32);
                send(0, cls, 5'($urandom), 5'($urandom), 5'($urandom), f3,
                     1'($urandom), imm, (i == len - 1), 1'b0, 32'd0);
                if (m_code[0] != 0) begin
                    errored = 1'b1;
                    check_err(0);
                end
            end
            if (!errored) wait_done(0);
        end

        // fill to DEPTH_WORDS, next command reports full
        do_start(0);
        for (int i = 0; i < 64; i++)
            send(0, 3'd0, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                 1'($urandom), 13'd0, 1'b0, 1'b0, 32'd0);
        send(0, 3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd0, 1'b0, 1'b0, 32'd0);
        check_err(0);
        check("full_count", 32'(count0), 32'd64);

        // small instance: two writes then full
        do_start(1);
        send(1, 3'd1, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 13'h1FFF, 1'b0, 1'b0, 32'd0);
        send(1, 3'd1, 5'd6, 5'd7, 5'd0, 3'd5, 1'b1, 13'd7, 1'b0, 1'b0, 32'd0);
        send(1, 3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd0, 1'b1, 1'b0, 32'd0);
        check_err(1);
        check("small_full_count", 32'(count1), 32'd2);

        // reset during WRITE
        do_start(0);
        send(0, 3'd0, 5'd9, 5'd8, 5'd7, 3'd4, 1'b0, 13'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_write_we", 32'(we0), 32'd0);
        check("rst_write_state", 32'(state0), 32'd0);
        check("rst_write_count", 32'(count0), 32'd0);
        check("rst_write_addr", addr0, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("small_queue_drained", 32'(exp_q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
